// File: rtl/fifo_packet_writer_pkg.sv
// Shared types and constants for the FIFO packet writer.
// FIFO_WR_CHECKSUM_EN adds the CHECK state used for the trailer byte.
package fifo_pkt_pkg;

  localparam int BYTE_W        = 8;
  localparam int MAX_LEN_LIMIT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISCARD,
    ST_HEADER,
    ST_PAYLOAD
`ifdef FIFO_WR_CHECKSUM_EN
    , ST_CHECK
`endif
  } state_e;

  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/fifo_packet_writer_if.sv
// Byte stream in, FIFO write port out, plus status flags.
// master drives stream and full; slave is the framer.
interface fifo_packet_writer_if;
  import fifo_pkt_pkg::*;

  logic              s_valid;
  logic [BYTE_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              full;
  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              busy;
  logic              ovf;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output full,
    input  s_ready,
    input  wr_en,
    input  wr_data,
    input  busy,
    input  ovf
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  full,
    output s_ready,
    output wr_en,
    output wr_data,
    output busy,
    output ovf
  );

endinterface

// File: rtl/fifo_packet_writer_ram.sv
// Store-and-forward packet buffer: sync write, async read.
// Contents are deliberately not reset.
module pkt_buffer_ram
  import fifo_pkt_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_packet_writer.sv
// Packet framer: buffers a byte stream, then writes length + payload.
// FIFO_WR_CHECKSUM_EN appends an XOR trailer byte after the payload.
module fifo_packet_writer
  import fifo_pkt_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input logic                 clk_write,
  input logic                 rst,
  fifo_packet_writer_if.slave bus
);

  localparam int AW = cnt_w(MAX_LEN);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     len_q, len_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic              rdy, wen, bsy, buf_we;
  logic [BYTE_W-1:0] wdat, rd_data;
  logic              take, fire, at_cap, last_idx;
`ifdef FIFO_WR_CHECKSUM_EN
  logic [BYTE_W-1:0] acc_q, acc_d;
`endif

  assign take     = bus.s_valid && rdy;
  assign fire     = wen;
  assign at_cap   = cnt_q == AW'(MAX_LEN);
  assign last_idx = idx_q == len_q - AW'(1);

  pkt_buffer_ram #(
    .DEPTH (MAX_LEN),
    .IW    (IW)
  ) u_buf (
    .clk_i   (clk_write),
    .we_i    (buf_we),
    .waddr_i (cnt_q[IW-1:0]),
    .wdata_i (bus.s_data),
    .raddr_i (idx_q[IW-1:0]),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (take) begin
          if (at_cap)
            state_d = bus.s_last ? ST_IDLE : ST_DISCARD;
          else
            state_d = bus.s_last ? ST_HEADER : ST_COLLECT;
        end
      end
      ST_DISCARD: begin
        if (take && bus.s_last) state_d = ST_IDLE;
      end
      ST_HEADER: begin
        if (fire) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (fire && last_idx) begin
`ifdef FIFO_WR_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef FIFO_WR_CHECKSUM_EN
      ST_CHECK: begin
        if (fire) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy    = 1'b0;
    wen    = 1'b0;
    wdat   = '0;
    buf_we = 1'b0;
    bsy    = state_q != ST_IDLE;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        rdy    = 1'b1;
        buf_we = bus.s_valid && !at_cap;
      end
      ST_DISCARD: rdy = 1'b1;
      ST_HEADER: begin
        wen  = !bus.full;
        wdat = BYTE_W'(len_q);
      end
      ST_PAYLOAD: begin
        wen  = !bus.full;
        wdat = rd_data;
      end
`ifdef FIFO_WR_CHECKSUM_EN
      ST_CHECK: begin
        wen  = !bus.full;
        wdat = acc_q;
      end
`endif
      default: ;
    endcase
  end

  // Counters and the ovf pulse; cnt is cleared on every entry to IDLE.
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    idx_d = idx_q;
    ovf_d = 1'b0;
`ifdef FIFO_WR_CHECKSUM_EN
    acc_d = acc_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (take) begin
          if (at_cap) begin
            if (bus.s_last) begin
              ovf_d = 1'b1;
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + AW'(1);
            if (bus.s_last) begin
              len_d = cnt_q + AW'(1);
              idx_d = '0;
`ifdef FIFO_WR_CHECKSUM_EN
              acc_d = '0;
`endif
            end
          end
        end
      end
      ST_DISCARD: begin
        if (take && bus.s_last) begin
          ovf_d = 1'b1;
          cnt_d = '0;
        end
      end
      ST_HEADER: begin
`ifdef FIFO_WR_CHECKSUM_EN
        if (fire) acc_d = acc_q ^ BYTE_W'(len_q);
`endif
      end
      ST_PAYLOAD: begin
        if (fire) begin
`ifdef FIFO_WR_CHECKSUM_EN
          acc_d = acc_q ^ rd_data;
`endif
          if (last_idx) begin
            idx_d = '0;
`ifndef FIFO_WR_CHECKSUM_EN
            cnt_d = '0;
`endif
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
`ifdef FIFO_WR_CHECKSUM_EN
      ST_CHECK: begin
        if (fire) cnt_d = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef FIFO_WR_CHECKSUM_EN
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`endif

  assign bus.s_ready = rdy;
  assign bus.wr_en   = wen;
  assign bus.wr_data = wdat;
  assign bus.busy    = bsy;
  assign bus.ovf     = ovf_q;

endmodule
